denise_collision_gen: RTL and testbench

Parametrised collision detector for Denise/Lisa, successor to the fixed OCS/AGA collision block. Compares serial bitplane data and sprite-group pixels every pixel tick, accumulates hits in CLXDAT (cleared after read), and adds two things the previous block lacks. First, a programmable collision interrupt mask. Second, a frozen capture of the beam position of the first masked collision since the last clear. It sits beside the sprite and bitplane shifters and drives the custom-register read mux and the interrupt controller.

---
 rtl/denise_collision_gen_if.sv | 10 +
 rtl/denise_collision_gen.sv | 144 ++++++++++++++
 tb/tb_denise_collision_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/denise_collision_gen_if.sv
// Custom-register bus between the chip register decoder and the collision block.
// The decoder (master) drives the address/write data; the block (slave) returns read data.
interface denise_collision_gen_if;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (output reg_address_in, output data_in, input data_out);
  modport slave  (input reg_address_in, input data_in, output data_out);
endinterface

// File: rtl/denise_collision_gen.sv
// Denise/Lisa collision detector: per-pixel bitplane/sprite comparison, sticky CLXDAT,
// interrupt mask and frozen beam position of the first masked collision since the last clear.
module denise_collision_gen #(
  parameter int         NPLANES   = 8,
  parameter int         NSPRGRP   = 4,
  parameter logic [8:0] CLXCON_A  = 9'h098,
  parameter logic [8:0] CLXCON2_A = 9'h10e,
  parameter logic [8:0] CLXDAT_A  = 9'h00e,
  parameter logic [8:0] CLXMSK_A  = 9'h1f0,
  parameter logic [8:0] CLXPOS_A  = 9'h1f2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk7_en,
  input  logic                   aga,
  denise_collision_gen_if.slave  bus,
  input  logic                   dblpf,
  input  logic [NPLANES-1:0]     bpldata,
  input  logic [2*NSPRGRP-1:0]   nsprite,
  input  logic [8:0]             hpos,
  input  logic [7:0]             vpos,
  output logic                   clx_irq
);

  logic [15:0] clxcon_reg,  clxcon_next;
  logic [15:0] clxcon2_reg, clxcon2_next;
  logic [14:0] clxmsk_reg,  clxmsk_next;
  logic [14:0] clxdat_reg,  clxdat_next;
  logic [15:0] clxpos_reg,  clxpos_next;
  logic        rd_d_reg;
  logic        clx_irq_reg, clx_irq_next;

  logic        wr_con, wr_con2, wr_msk, rd_dat, rd_pos, clr;
  logic [14:0] clxdat_base;
  logic [7:0]  en_all, mv_all;
  logic [NPLANES-1:0]   bm;
  logic [NPLANES/2-1:0] bm_lo, bm_hi;
  logic        evenmatch, oddmatch;
  logic [3:0]  sm;
  logic [14:0] cl;
  logic        unused_bits;

  assign wr_con  = (bus.reg_address_in == CLXCON_A[8:1]);
  assign wr_con2 = (bus.reg_address_in == CLXCON2_A[8:1]);
  assign wr_msk  = (bus.reg_address_in == CLXMSK_A[8:1]);
  assign rd_dat  = (bus.reg_address_in == CLXDAT_A[8:1]);
  assign rd_pos  = (bus.reg_address_in == CLXPOS_A[8:1]);

  // Planes 6/7 are controlled from CLXCON2; narrower builds simply drop them.
  assign en_all = {clxcon2_reg[7:6], clxcon_reg[11:6]};
  assign mv_all = {clxcon2_reg[1:0], clxcon_reg[5:0]};

  genvar gi;
  generate
    for (gi = 0; gi < NPLANES; gi++) begin : g_plane
      assign bm[gi] = (bpldata[gi] ~^ mv_all[gi]) | ~en_all[gi];
    end
    for (gi = 0; gi < NPLANES/2; gi++) begin : g_split
      assign bm_lo[gi] = bm[2*gi];
      assign bm_hi[gi] = bm[2*gi+1];
    end
    for (gi = 0; gi < 4; gi++) begin : g_spr
      if (gi < NSPRGRP) begin : g_present
        assign sm[gi] = nsprite[2*gi] | (nsprite[2*gi+1] & clxcon_reg[12+gi]);
      end else begin : g_absent
        assign sm[gi] = 1'b0;
      end
    end
  endgenerate

  assign evenmatch = &bm_hi;
  // Odd match is gated by even match outside dual-playfield, as real Denise does.
  assign oddmatch  = (&bm_lo) & (dblpf | evenmatch);

  assign cl[0]    = evenmatch & oddmatch;
  assign cl[4:1]  = {4{oddmatch}}  & sm;
  assign cl[8:5]  = {4{evenmatch}} & sm;
  assign cl[14:9] = {sm[2] & sm[3], sm[1] & sm[3], sm[1] & sm[2],
                     sm[0] & sm[3], sm[0] & sm[2], sm[0] & sm[1]};

  always_comb begin
    clxcon_next  = clxcon_reg;
    clxcon2_next = clxcon2_reg;
    clxmsk_next  = clxmsk_reg;
    if (wr_con) begin
      clxcon_next  = bus.data_in;
      clxcon2_next = 16'h0000;
    end else if (wr_con2 && aga && (NPLANES == 8)) begin
      clxcon2_next = bus.data_in;
    end
    if (wr_msk) begin
      clxmsk_next = bus.data_in[14:0];
    end

    // The clear tick is the first tick after a read ends; its own hits survive.
    clr         = rd_d_reg & ~rd_dat;
    clxdat_base = clr ? 15'h0000 : clxdat_reg;
    clxdat_next = clxdat_base | cl;

    clxpos_next = clxpos_reg;
    if (((clxdat_base & clxmsk_reg) == 15'h0000) && ((cl & clxmsk_reg) != 15'h0000)) begin
      clxpos_next = {vpos, hpos[8:1]};
    end else if (clr) begin
      clxpos_next = 16'h0000;
    end

    clx_irq_next = |(clxdat_reg & clxmsk_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clxcon_reg  <= 16'h0fff;
      clxcon2_reg <= 16'h0000;
      clxmsk_reg  <= 15'h0000;
      clxdat_reg  <= 15'h0000;
      clxpos_reg  <= 16'h0000;
      rd_d_reg    <= 1'b0;
      clx_irq_reg <= 1'b0;
    end else if (clk7_en) begin
      clxcon_reg  <= clxcon_next;
      clxcon2_reg <= clxcon2_next;
      clxmsk_reg  <= clxmsk_next;
      clxdat_reg  <= clxdat_next;
      clxpos_reg  <= clxpos_next;
      rd_d_reg    <= rd_dat;
      clx_irq_reg <= clx_irq_next;
    end
  end

  assign clx_irq = clx_irq_reg;

  always_comb begin
    bus.data_out = 16'h0000;
    if (rd_dat) begin
      bus.data_out = {1'b1, clxdat_reg};
    end else if (rd_pos) begin
      bus.data_out = clxpos_reg;
    end
  end

  assign unused_bits = &{1'b0, bus.data_in[15], hpos[0], clxcon_reg[15:12],
                         clxcon2_reg, en_all, mv_all};

endmodule

// File: tb/tb_denise_collision_gen.sv
// Directed bench for denise_collision_gen: hand-computed CLXDAT/CLXPOS/irq values.
module tb_denise_collision_gen;

  localparam logic [8:1] A_IDLE = 8'hff;
  localparam logic [8:1] A_CON  = 8'h4c;
  localparam logic [8:1] A_CON2 = 8'h87;
  localparam logic [8:1] A_DAT  = 8'h07;
  localparam logic [8:1] A_MSK  = 8'hf8;
  localparam logic [8:1] A_POS  = 8'hf9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk7_en = 1'b1;
  logic       aga = 1'b0;
  logic       dblpf = 1'b0;
  logic [7:0] bpldata = 8'h00;
  logic [7:0] nsprite = 8'h00;
  logic [8:0] hpos = 9'h000;
  logic [7:0] vpos = 8'h00;
  logic       clx_irq;

  int n_cmp = 0;
  int n_bad = 0;

  denise_collision_gen_if bus ();

  denise_collision_gen #(.NPLANES(8), .NSPRGRP(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .aga     (aga),
    .bus     (bus),
    .dblpf   (dblpf),
    .bpldata (bpldata),
    .nsprite (nsprite),
    .hpos    (hpos),
    .vpos    (vpos),
    .clx_irq (clx_irq)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %-10s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %-10s got %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:1] addr, input logic [15:0] data);
    bus.reg_address_in = addr;
    bus.data_in        = data;
    tick();
    bus.reg_address_in = A_IDLE;
    bus.data_in        = 16'h0000;
  endtask

  // Read CLXDAT for one tick, then release so the following tick is the clear tick.
  task automatic rd_dat(input string tag, input logic [15:0] exp);
    bus.reg_address_in = A_DAT;
    #1;
    check_value(tag, bus.data_out, exp);
    tick();
    bus.reg_address_in = A_IDLE;
    tick();
  endtask

  task automatic rd_addr(input string tag, input logic [8:1] addr, input logic [15:0] exp);
    bus.reg_address_in = addr;
    #1;
    check_value(tag, bus.data_out, exp);
    bus.reg_address_in = A_IDLE;
  endtask

  task automatic pixel(input logic [7:0] bpl, input logic [7:0] spr);
    bpldata = bpl;
    nsprite = spr;
    tick();
    bpldata = 8'h00;
    nsprite = 8'h00;
  endtask

  initial begin
    bus.reg_address_in = A_IDLE;
    bus.data_in        = 16'h0000;

    // Reset state
    tick();
    tick();
    rd_addr("rst_idle", A_IDLE, 16'h0000);
    check_value("rst_irq", {15'h0, clx_irq}, 16'h0000);
    rd_addr("rst_dat", A_DAT, 16'h8000);
    reset_n = 1'b1;
    tick();
    tick();

    // Even/odd playfield collision with reset CLXCON
    dblpf = 1'b1;
    pixel(8'h3f, 8'h00);
    rd_dat("evenodd", 16'h8001);
    rd_dat("cleared", 16'h8000);

    // Odd match gated by even match when not dual-playfield
    dblpf = 1'b0;
    pixel(8'h15, 8'h01);
    rd_dat("oddgate", 16'h8000);
    dblpf = 1'b1;
    pixel(8'h15, 8'h01);
    rd_dat("oddspr0", 16'h8002);

    // Sprite pairs, odd sprites enabled through CLXCON[13:12]
    pixel(8'h00, 8'h05);
    rd_dat("pair02", 16'h8200);
    pixel(8'h00, 8'h0a);
    rd_dat("odd_off", 16'h8000);
    wr(A_CON, 16'h3fff);
    pixel(8'h00, 8'h0a);
    rd_dat("odd_on", 16'h8200);

    // First masked collision captures position; irq one tick later
    wr(A_MSK, 16'h0200);
    hpos = 9'h0a0;
    vpos = 8'h40;
    pixel(8'h00, 8'h05);
    check_value("irq_lat", {15'h0, clx_irq}, 16'h0000);
    hpos = 9'h100;
    vpos = 8'h22;
    tick();
    check_value("irq_rise", {15'h0, clx_irq}, 16'h0001);
    pixel(8'h00, 8'h05);
    rd_addr("pos_hold", A_POS, 16'h4050);
    rd_dat("pos_dat", 16'h8200);
    check_value("irq_tail", {15'h0, clx_irq}, 16'h0001);
    tick();
    check_value("irq_fall", {15'h0, clx_irq}, 16'h0000);
    rd_addr("pos_clr", A_POS, 16'h0000);

    // data_in[15] is not a mask bit
    wr(A_MSK, 16'h8000);
    pixel(8'h00, 8'h05);
    tick();
    check_value("msk_b15", {15'h0, clx_irq}, 16'h0000);
    rd_dat("msk_dat", 16'h8200);

    // Collision on the clear tick is retained and captures position
    wr(A_MSK, 16'h0200);
    hpos = 9'h034;
    vpos = 8'h12;
    pixel(8'h3f, 8'h00);
    bus.reg_address_in = A_DAT;
    #1;
    check_value("ct_pre", bus.data_out, 16'h8001);
    tick();
    bus.reg_address_in = A_IDLE;
    pixel(8'h00, 8'h05);
    rd_addr("ct_pos", A_POS, 16'h121a);
    rd_dat("ct_keep", 16'h8200);

    // Multi-tick read keeps accumulating and defers the clear
    bus.reg_address_in = A_DAT;
    #1;
    check_value("mr_0", bus.data_out, 16'h8000);
    tick();
    pixel(8'h3f, 8'h00);
    check_value("mr_acc", bus.data_out, 16'h8001);
    tick();
    check_value("mr_hold", bus.data_out, 16'h8001);
    bus.reg_address_in = A_IDLE;
    tick();
    rd_dat("mr_clr", 16'h8000);

    // CLXCON2 accepted only in AGA mode; CLXCON write clears it
    aga = 1'b0;
    wr(A_CON2, 16'h00c3);
    pixel(8'h3f, 8'h00);
    rd_dat("aga_off", 16'h8001);
    aga = 1'b1;
    wr(A_CON2, 16'h00c3);
    pixel(8'h3f, 8'h00);
    rd_dat("aga_3f", 16'h8000);
    pixel(8'hff, 8'h00);
    rd_dat("aga_ff", 16'h8001);
    wr(A_CON, 16'h3fff);
    pixel(8'h3f, 8'h00);
    rd_dat("con_rst2", 16'h8001);
    aga = 1'b0;

    // No state change without pixel tick
    clk7_en = 1'b0;
    bpldata = 8'h3f;
    tick();
    tick();
    bpldata = 8'h00;
    clk7_en = 1'b1;
    rd_dat("en_hold", 16'h8000);

    // Write-only registers read as zero
    rd_addr("rd_msk", A_MSK, 16'h0000);
    rd_addr("rd_con", A_CON, 16'h0000);

    // Asynchronous reset mid-frame, no clock edge or tick needed
    pixel(8'h00, 8'h05);
    tick();
    check_value("irq_pre", {15'h0, clx_irq}, 16'h0001);
    clk7_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_value("arst_irq", {15'h0, clx_irq}, 16'h0000);
    rd_addr("arst_dat", A_DAT, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
